// File: rtl/l2_input_arbiter_p.sv
// L2 input arbiter: picks one of flush start, rsp, fwd, flush-sweep step, cpu_req or idle
// per decode slot, and registers the chosen action plus address breakdowns for the next stage.
module l2_input_arbiter_p #(
    parameter int ADDR_BITS   = 32,
    parameter int OFFSET_BITS = 4,
    parameter int SET_BITS    = 9,
    parameter int WAYS        = 8,
    parameter int N_MSHR      = 4,
    localparam int W_OFF_BITS = OFFSET_BITS - 2,
    localparam int WAY_BITS   = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int CNT_BITS   = $clog2(N_MSHR + 1),
    localparam int LINE_BITS  = ADDR_BITS - OFFSET_BITS,
    localparam int TAG_BITS   = LINE_BITS - SET_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  decode_en,
    input  logic                  flush_valid,
    input  logic                  rsp_in_valid,
    input  logic                  fwd_in_valid,
    input  logic                  cpu_req_valid,
    input  logic [CNT_BITS-1:0]   mshr_cnt,
    input  logic                  fwd_stall,
    input  logic                  fwd_stall_ended,
    input  logic                  set_conflict,
    input  logic                  evict_stall,
    input  logic                  ongoing_atomic,
    input  logic [LINE_BITS-1:0]  rsp_in_addr,
    input  logic [LINE_BITS-1:0]  fwd_in_addr,
    input  logic [ADDR_BITS-1:0]  cpu_req_addr,
    output logic                  flush_ready,
    output logic                  rsp_in_ready,
    output logic                  fwd_in_ready,
    output logic                  cpu_req_ready,
    output logic                  do_flush,
    output logic                  do_rsp,
    output logic                  do_fwd,
    output logic                  do_flush_step,
    output logic                  do_cpu_req,
    output logic                  fwd_from_stalled,
    output logic                  cpu_from_conflict,
    output logic [TAG_BITS-1:0]   line_tag,
    output logic [SET_BITS-1:0]   line_set,
    output logic [TAG_BITS-1:0]   cpu_tag,
    output logic [SET_BITS-1:0]   cpu_set,
    output logic [W_OFF_BITS-1:0] cpu_w_off,
    output logic [1:0]            cpu_b_off,
    output logic [LINE_BITS-1:0]  cpu_line_addr,
    output logic [SET_BITS-1:0]   flush_set,
    output logic [WAY_BITS-1:0]   flush_way,
    output logic                  flush_busy,
    output logic                  flush_done
);

    localparam logic [CNT_BITS-1:0] MSHR_ALL = CNT_BITS'(N_MSHR);
    localparam logic [SET_BITS-1:0] SET_LAST = '1;
    localparam logic [WAY_BITS-1:0] WAY_LAST = WAY_BITS'(WAYS - 1);

    typedef enum logic {
        S_IDLE,
        S_SWEEP
    } sweep_state_e;

    sweep_state_e          state_q, state_d;
    logic [SET_BITS-1:0]   set_cnt_q, set_cnt_d;
    logic [WAY_BITS-1:0]   way_cnt_q, way_cnt_d;

    logic                  do_flush_q, do_flush_d;
    logic                  do_rsp_q, do_rsp_d;
    logic                  do_fwd_q, do_fwd_d;
    logic                  do_flush_step_q, do_flush_step_d;
    logic                  do_cpu_req_q, do_cpu_req_d;
    logic                  fwd_from_stalled_q, fwd_from_stalled_d;
    logic                  cpu_from_conflict_q, cpu_from_conflict_d;
    logic [TAG_BITS-1:0]   line_tag_q, line_tag_d;
    logic [SET_BITS-1:0]   line_set_q, line_set_d;
    logic [TAG_BITS-1:0]   cpu_tag_q, cpu_tag_d;
    logic [SET_BITS-1:0]   cpu_set_q, cpu_set_d;
    logic [W_OFF_BITS-1:0] cpu_w_off_q, cpu_w_off_d;
    logic [1:0]            cpu_b_off_q, cpu_b_off_d;
    logic [LINE_BITS-1:0]  cpu_line_addr_q, cpu_line_addr_d;
    logic [SET_BITS-1:0]   flush_set_q, flush_set_d;
    logic [WAY_BITS-1:0]   flush_way_q, flush_way_d;
    logic                  flush_done_q, flush_done_d;

    logic busy, mshr_all, mshr_none;
    logic sel_flush, sel_rsp, sel_fwd, sel_step, sel_cpu;

    assign busy      = (state_q == S_SWEEP);
    assign mshr_all  = (mshr_cnt == MSHR_ALL);
    assign mshr_none = (mshr_cnt == '0);

    // Fixed-priority chain: each stage is masked by every higher-priority selection.
    assign sel_flush = decode_en && flush_valid && !busy && mshr_all;
    assign sel_rsp   = decode_en && !sel_flush && rsp_in_valid && !mshr_all;
    assign sel_fwd   = decode_en && !sel_flush && !sel_rsp &&
                       ((fwd_in_valid && !fwd_stall) || fwd_stall_ended);
    assign sel_step  = decode_en && !sel_flush && !sel_rsp && !sel_fwd &&
                       busy && !fwd_in_valid && !mshr_none;
    assign sel_cpu   = decode_en && !sel_flush && !sel_rsp && !sel_fwd && !sel_step &&
                       (cpu_req_valid || set_conflict) && !evict_stall &&
                       (!mshr_none || ongoing_atomic);

    assign flush_ready   = sel_flush;
    assign rsp_in_ready  = sel_rsp;
    assign fwd_in_ready  = sel_fwd && !fwd_stall;
    assign cpu_req_ready = sel_cpu && !set_conflict;

    always_comb begin
        state_d             = state_q;
        set_cnt_d           = set_cnt_q;
        way_cnt_d           = way_cnt_q;
        do_flush_d          = sel_flush;
        do_rsp_d            = sel_rsp;
        do_fwd_d            = sel_fwd;
        do_flush_step_d     = sel_step;
        do_cpu_req_d        = sel_cpu;
        fwd_from_stalled_d  = sel_fwd && fwd_stall;
        cpu_from_conflict_d = sel_cpu && set_conflict;
        line_tag_d          = line_tag_q;
        line_set_d          = line_set_q;
        cpu_tag_d           = cpu_tag_q;
        cpu_set_d           = cpu_set_q;
        cpu_w_off_d         = cpu_w_off_q;
        cpu_b_off_d         = cpu_b_off_q;
        cpu_line_addr_d     = cpu_line_addr_q;
        flush_set_d         = flush_set_q;
        flush_way_d         = flush_way_q;
        flush_done_d        = 1'b0;

        if (decode_en) begin
            if (sel_rsp) begin
                line_tag_d = rsp_in_addr[LINE_BITS-1:SET_BITS];
                line_set_d = rsp_in_addr[SET_BITS-1:0];
            end else if (sel_fwd) begin
                line_tag_d = fwd_in_addr[LINE_BITS-1:SET_BITS];
                line_set_d = fwd_in_addr[SET_BITS-1:0];
            end else begin
                line_tag_d = '0;
                line_set_d = '0;
            end
            cpu_tag_d       = cpu_req_addr[ADDR_BITS-1:OFFSET_BITS+SET_BITS];
            cpu_set_d       = cpu_req_addr[OFFSET_BITS+SET_BITS-1:OFFSET_BITS];
            cpu_w_off_d     = cpu_req_addr[OFFSET_BITS-1:2];
            cpu_b_off_d     = cpu_req_addr[1:0];
            cpu_line_addr_d = cpu_req_addr[ADDR_BITS-1:OFFSET_BITS];
        end

        if (sel_flush) begin
            state_d   = S_SWEEP;
            set_cnt_d = '0;
            way_cnt_d = '0;
        end

        // Counters only advance on a granted step, so preempting slots keep the position.
        if (sel_step) begin
            flush_set_d = set_cnt_q;
            flush_way_d = way_cnt_q;
            if (way_cnt_q == WAY_LAST) begin
                way_cnt_d = '0;
                set_cnt_d = set_cnt_q + 1'b1;
                if (set_cnt_q == SET_LAST) begin
                    state_d      = S_IDLE;
                    flush_done_d = 1'b1;
                end
            end else begin
                way_cnt_d = way_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q             <= S_IDLE;
            set_cnt_q           <= '0;
            way_cnt_q           <= '0;
            do_flush_q          <= 1'b0;
            do_rsp_q            <= 1'b0;
            do_fwd_q            <= 1'b0;
            do_flush_step_q     <= 1'b0;
            do_cpu_req_q        <= 1'b0;
            fwd_from_stalled_q  <= 1'b0;
            cpu_from_conflict_q <= 1'b0;
            line_tag_q          <= '0;
            line_set_q          <= '0;
            cpu_tag_q           <= '0;
            cpu_set_q           <= '0;
            cpu_w_off_q         <= '0;
            cpu_b_off_q         <= '0;
            cpu_line_addr_q     <= '0;
            flush_set_q         <= '0;
            flush_way_q         <= '0;
            flush_done_q        <= 1'b0;
        end else begin
            state_q             <= state_d;
            set_cnt_q           <= set_cnt_d;
            way_cnt_q           <= way_cnt_d;
            do_flush_q          <= do_flush_d;
            do_rsp_q            <= do_rsp_d;
            do_fwd_q            <= do_fwd_d;
            do_flush_step_q     <= do_flush_step_d;
            do_cpu_req_q        <= do_cpu_req_d;
            fwd_from_stalled_q  <= fwd_from_stalled_d;
            cpu_from_conflict_q <= cpu_from_conflict_d;
            line_tag_q          <= line_tag_d;
            line_set_q          <= line_set_d;
            cpu_tag_q           <= cpu_tag_d;
            cpu_set_q           <= cpu_set_d;
            cpu_w_off_q         <= cpu_w_off_d;
            cpu_b_off_q         <= cpu_b_off_d;
            cpu_line_addr_q     <= cpu_line_addr_d;
            flush_set_q         <= flush_set_d;
            flush_way_q         <= flush_way_d;
            flush_done_q        <= flush_done_d;
        end
    end

    assign do_flush          = do_flush_q;
    assign do_rsp            = do_rsp_q;
    assign do_fwd            = do_fwd_q;
    assign do_flush_step     = do_flush_step_q;
    assign do_cpu_req        = do_cpu_req_q;
    assign fwd_from_stalled  = fwd_from_stalled_q;
    assign cpu_from_conflict = cpu_from_conflict_q;
    assign line_tag          = line_tag_q;
    assign line_set          = line_set_q;
    assign cpu_tag           = cpu_tag_q;
    assign cpu_set           = cpu_set_q;
    assign cpu_w_off         = cpu_w_off_q;
    assign cpu_b_off         = cpu_b_off_q;
    assign cpu_line_addr     = cpu_line_addr_q;
    assign flush_set         = flush_set_q;
    assign flush_way         = flush_way_q;
    assign flush_busy        = busy;
    assign flush_done        = flush_done_q;

endmodule
